stream_demux_1_2: RTL
=====================

Name: stream_demux_1_2

Overview:
- 1:2 stream demultiplexer: the splitting counterpart to the team's 2:1 mux.
- Routes a valid/ready input stream to one of two registered output streams. Selection is per packet: it is latched on the first beat and held until the beat carrying `in_last`.
- Sits after a merge point and fans traffic back out to two consumers. Each output has a one-entry register stage, so both outputs are timing-clean.

Parameters:
- WIDTH, 2, data width of every stream.
- CNTW, 8, width of per-output beat counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- in_data  in  WIDTH  input beat payload.
- in_valid  in  1  input beat present.
- in_last  in  1  final beat of packet.
- in_sel  in  1  destination of packet, 0 -> out0, 1 -> out1; sampled on first beat only.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- out0_data  out  WIDTH  channel 0 payload.
- out0_valid  out  1  channel 0 beat present.
- out0_last  out  1  channel 0 final beat.
- out0_ready  in  1  channel 0 consumer ready.
- out1_data, out1_valid, out1_last, out1_ready: as for channel 0.
- busy  out  1  high while mid-packet (state LOCKED).

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - `rst` is asynchronous, active-high, and is the only reset.
- Reset values:
  - state = IDLE.
  - outN_valid = 0, outN_data = 0, outN_last = 0.
  - busy = 0, lock_sel = 0.
  - in_ready forced to 0 while rst is high.
- Free condition per channel: freeN = !outN_valid || outN_ready.
- Destination:
  - dest = in_sel in IDLE.
  - dest = lock_sel in LOCKED.
- in_ready (combinational, zero-cycle path from outN_ready) = free[dest] && !rst.
- Accept: acc = in_valid && in_ready. On acc, outputs load at the next edge:
  - out[dest]_data <= in_data.
  - out[dest]_last <= in_last.
  - out[dest]_valid <= 1.
- Latency: exactly 1 cycle from accepted input to outN_valid.
- Throughput: 1 beat/cycle while the consumer holds ready high.
- Drain: if outN_valid && outN_ready and no load to channel N this cycle, then outN_valid <= 0. Data and last hold their values (don't-care once valid is low).
- Simultaneous drain + load on the same channel: the new beat is registered and valid stays 1. No bubble, no loss.
- Stall: while outN_valid && !outN_ready, outN_data and outN_last hold stable. in_ready stays 0 if that channel is the dest.
- The non-destination channel drains independently and is never written.
- FSM:
  - IDLE, acc && !in_last -> LOCKED, lock_sel <= in_sel.
  - IDLE, acc && in_last -> IDLE (single-beat packet).
  - LOCKED, acc && in_last -> IDLE.
  - LOCKED, otherwise -> LOCKED.
  - in_sel is ignored in LOCKED.
- busy = (state == LOCKED).
- in_valid low: no state change; buffers drain only.
- in_data, in_last and in_sel are sampled only on acc cycles. in_valid may drop mid-packet with no effect on state.
- Reset mid-packet: immediate return to IDLE; buffered beats are discarded and outN_valid goes low asynchronously. The next packet's first beat samples in_sel afresh.

Optional Feature:
- Macro: STREAM_DEMUX_BEAT_COUNT_EN.
- Defined:
  - Adds ports cnt0 and cnt1, each out, CNTW wide.
  - Each counts beats accepted into channel N (increment on acc && dest==N).
  - Wraps modulo 2^CNTW, from all-ones to 0.
  - Reset value 0 on rst.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset mid-flow: load out0 with data 2'b10, hold out0_ready=0, assert rst -> out0_valid=0 and busy=0 immediately. After release, a beat with in_sel=1 lands on out1.
- Single-beat routing: in_sel=0, in_data=2'b01, in_last=1, both readies high -> out0_valid=1 and out0_data=2'b01 one cycle later. out1_valid stays 0. busy never rises.
- Packet lock: 3-beat packet 2'b11, 2'b10, 2'b01 with in_sel=1 on beat 1, then in_sel=0 on beats 2-3 -> all three appear on out1 back-to-back with out1_last only on 2'b01. busy=1 from after beat 1 through the beat-3 accept.
- Backpressure: out0_ready=0 with out0 holding 2'b10, new beat for out0 offered -> in_ready=0 and out0_data stays 2'b10. Raise out0_ready -> in_ready=1 the same cycle, next beat loads with no gap.
- Independent drain: out1 full and stalled, packet to out0 -> in_ready=1 and out0 streams at 1 beat/cycle. out1 holds its data.
- With STREAM_DEMUX_BEAT_COUNT_EN and CNTW=2: 5 beats to out1 -> cnt1 sequence 1,2,3,0,1 and cnt0=0.

Source files
------------

// File: rtl/stream_demux_1_2.sv
// 1:2 packet-aware stream demultiplexer with a one-entry register stage per output.
// Optional per-output beat counters are enabled with `define STREAM_DEMUX_BEAT_COUNT_EN.
module stream_demux_1_2 #(
    parameter int WIDTH = 2,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             in_sel,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    output logic             out0_last,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    output logic             out1_last,
    input  logic             out1_ready,
    output logic             busy
`ifdef STREAM_DEMUX_BEAT_COUNT_EN
    ,
    output logic [CNTW-1:0]  cnt0,
    output logic [CNTW-1:0]  cnt1
`endif
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0] state;
    logic       lock_sel;
    logic       free0;
    logic       free1;
    logic       dest;
    logic       acc;
    logic       load0;
    logic       load1;

    // A channel can take a beat if it is empty or draining this cycle.
    assign free0    = !out0_valid || out0_ready;
    assign free1    = !out1_valid || out1_ready;
    assign dest     = (state == IDLE) ? in_sel : lock_sel;
    assign in_ready = (dest ? free1 : free0) && !rst;
    assign acc      = in_valid && in_ready;
    assign load0    = acc && !dest;
    assign load1    = acc && dest;
    assign busy     = (state == LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lock_sel <= 1'b0;
        end else if (acc) begin
            if (in_last) begin
                state <= IDLE;
            end else if (state == IDLE) begin
                state    <= LOCKED;
                lock_sel <= in_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out0_valid <= 1'b0;
            out0_data  <= '0;
            out0_last  <= 1'b0;
        end else if (load0) begin
            out0_valid <= 1'b1;
            out0_data  <= in_data;
            out0_last  <= in_last;
        end else if (out0_ready) begin
            out0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out1_valid <= 1'b0;
            out1_data  <= '0;
            out1_last  <= 1'b0;
        end else if (load1) begin
            out1_valid <= 1'b1;
            out1_data  <= in_data;
            out1_last  <= in_last;
        end else if (out1_ready) begin
            out1_valid <= 1'b0;
        end
    end

`ifdef STREAM_DEMUX_BEAT_COUNT_EN
    // Counters wrap naturally from all-ones to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (load0) cnt0 <= cnt0 + 1'b1;
            if (load1) cnt1 <= cnt1 + 1'b1;
        end
    end
`endif

endmodule
